// File: rtl/mealy_fsm_1010_pkg.sv
// Shared types and constants for the 1010 Mealy sequence detector.
package mealy_fsm_1010_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } state_t;

    localparam logic [3:0] PATTERN = 4'b1010;

endpackage

// File: rtl/mealy_fsm_1010_det.sv
// Mealy detector for serial pattern 1010 with selectable overlap.
// Define MEALY_FSM_1010_CNT_EN to add a saturating match counter (match_count, CNT_W bits).
module mealy_fsm_1010_det
    import mealy_fsm_1010_pkg::*;
#(
    parameter int OVERLAP = 1
`ifdef MEALY_FSM_1010_CNT_EN
    ,
    parameter int CNT_W = 8
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out
`ifdef MEALY_FSM_1010_CNT_EN
    ,
    output logic [CNT_W-1:0] match_count
`endif
);

    state_t state;
    state_t next_state;
    logic   match;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S0;
        end else begin
            state <= next_state;
        end
    end

    // Each state records the longest pattern prefix seen; unknown encodings fall back to idle.
    always_comb begin
        next_state = S0;
        match      = 1'b0;
        case (state)
            S0: next_state = (in == PATTERN[3]) ? S1 : S0;
            S1: next_state = (in == PATTERN[2]) ? S2 : S1;
            S2: next_state = (in == PATTERN[1]) ? S3 : S0;
            S3: begin
                if (in == PATTERN[0]) begin
                    match      = 1'b1;
                    next_state = (OVERLAP != 0) ? S2 : S0;
                end else begin
                    next_state = S1;
                end
            end
            default: next_state = S0;
        endcase
    end

    assign out = match & ~rst;

`ifdef MEALY_FSM_1010_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            match_count <= '0;
        end else if (out && (match_count != {CNT_W{1'b1}})) begin
            match_count <= match_count + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mealy_fsm_1010_det.sv
// Testbench for mealy_fsm_1010_det: overlapping and non-overlapping instances against a history-based model.
// Counter checks are included when MEALY_FSM_1010_CNT_EN is defined.
module tb_mealy_fsm_1010_det;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic din = 1'b0;
    logic out_ov;
    logic out_nov;
    int   checks = 0;
    int   failures = 0;

`ifdef MEALY_FSM_1010_CNT_EN
    localparam int CMAX = 3;
    logic [1:0] cnt_ov;
    logic [1:0] cnt_nov;
`else
    localparam int CMAX = 1 << 30;
`endif

    always #5 clk = ~clk;

    mealy_fsm_1010_det #(
        .OVERLAP(1)
`ifdef MEALY_FSM_1010_CNT_EN
        , .CNT_W(2)
`endif
    ) dut_ov (
        .clk(clk),
        .rst(rst),
        .in(din),
        .out(out_ov)
`ifdef MEALY_FSM_1010_CNT_EN
        , .match_count(cnt_ov)
`endif
    );

    mealy_fsm_1010_det #(
        .OVERLAP(0)
`ifdef MEALY_FSM_1010_CNT_EN
        , .CNT_W(2)
`endif
    ) dut_nov (
        .clk(clk),
        .rst(rst),
        .in(din),
        .out(out_nov)
`ifdef MEALY_FSM_1010_CNT_EN
        , .match_count(cnt_nov)
`endif
    );

    // Reference model: the recent bits that can still form a match, plus saturating match counts.
    bit hist_ov[$];
    bit hist_nov[$];
    int mcnt_ov = 0;
    int mcnt_nov = 0;

    function automatic bit ends_101(input bit h[$]);
        int n = h.size();
        if (n < 3) return 1'b0;
        return (h[n-3] == 1'b1) && (h[n-2] == 1'b0) && (h[n-1] == 1'b1);
    endfunction

    function automatic bit exp_ov();
        return !rst && (din == 1'b0) && ends_101(hist_ov);
    endfunction

    function automatic bit exp_nov();
        return !rst && (din == 1'b0) && ends_101(hist_nov);
    endfunction

    task automatic model_edge();
        bit m_ov;
        bit m_nov;
        if (rst) begin
            hist_ov.delete();
            hist_nov.delete();
            mcnt_ov  = 0;
            mcnt_nov = 0;
        end else begin
            m_ov  = exp_ov();
            m_nov = exp_nov();
            if (m_ov && mcnt_ov < CMAX) mcnt_ov++;
            if (m_nov && mcnt_nov < CMAX) mcnt_nov++;
            hist_ov.push_back(din);
            if (hist_ov.size() > 3) void'(hist_ov.pop_front());
            if (m_nov) begin
                hist_nov.delete();
            end else begin
                hist_nov.push_back(din);
                if (hist_nov.size() > 3) void'(hist_nov.pop_front());
            end
        end
    endtask

    task automatic drive(input bit b, input bit r);
        @(negedge clk);
        din = b;
        rst = r;
        #1;
    endtask

    task automatic clock_edge();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1);
        checks++;
        if (out_ov !== 1'b0 || out_nov !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_out: out_ov=%b out_nov=%b expected 0", out_ov, out_nov);
        end
        clock_edge();
`ifdef MEALY_FSM_1010_CNT_EN
        checks++;
        if (cnt_ov !== 2'd0 || cnt_nov !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_count: cnt_ov=%0d cnt_nov=%0d expected 0", cnt_ov, cnt_nov);
        end
`endif
    endtask

    task automatic test_alternating();
        bit seq[] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};
        int hits_ov = 0;
        int hits_nov = 0;
        drive(1'b0, 1'b1);
        clock_edge();
        foreach (seq[i]) begin
            drive(seq[i], 1'b0);
            checks++;
            if (out_ov !== exp_ov() || out_nov !== exp_nov()) begin
                failures++;
                $display("[TB] FAIL alt_bit%0d: out_ov=%b out_nov=%b expected %b %b",
                         i + 1, out_ov, out_nov, exp_ov(), exp_nov());
            end
            if (out_ov === 1'b1) hits_ov++;
            if (out_nov === 1'b1) hits_nov++;
            clock_edge();
        end
        checks++;
        if (hits_ov != 3 || hits_nov != 2) begin
            failures++;
            $display("[TB] FAIL alt_hits: ov=%0d nov=%0d expected 3 2", hits_ov, hits_nov);
        end
    endtask

    task automatic test_near_miss();
        bit seq[] = '{1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 0, 1, 0};
        int early_hits = 0;
        int hits_nov = 0;
        drive(1'b0, 1'b1);
        clock_edge();
        foreach (seq[i]) begin
            drive(seq[i], 1'b0);
            checks++;
            if (out_ov !== exp_ov() || out_nov !== exp_nov()) begin
                failures++;
                $display("[TB] FAIL near_bit%0d: out_ov=%b out_nov=%b expected %b %b",
                         i + 1, out_ov, out_nov, exp_ov(), exp_nov());
            end
            if (i < 9 && (out_ov !== 1'b0 || out_nov !== 1'b0)) early_hits++;
            if (out_nov === 1'b1) hits_nov++;
            clock_edge();
        end
        checks++;
        if (early_hits != 0 || hits_nov != 1) begin
            failures++;
            $display("[TB] FAIL near_hits: early=%0d nov=%0d expected 0 1", early_hits, hits_nov);
        end
    endtask

    task automatic test_mid_reset();
        bit seq[] = '{1, 0, 1};
        bit post[] = '{0, 1, 0, 1, 0};
        drive(1'b0, 1'b1);
        clock_edge();
        foreach (seq[i]) begin
            drive(seq[i], 1'b0);
            clock_edge();
        end
        drive(1'b0, 1'b1);
        checks++;
        if (out_ov !== 1'b0 || out_nov !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mask: out_ov=%b out_nov=%b expected 0", out_ov, out_nov);
        end
        clock_edge();
        // A leftover 101 prefix would make the first 0 after reset a match.
        foreach (post[i]) begin
            drive(post[i], 1'b0);
            checks++;
            if (out_ov !== exp_ov() || out_nov !== exp_nov() || (i < 4 && out_ov !== 1'b0)) begin
                failures++;
                $display("[TB] FAIL mid_reset_bit%0d: out_ov=%b out_nov=%b expected %b %b",
                         i + 1, out_ov, out_nov, exp_ov(), exp_nov());
            end
            clock_edge();
        end
    endtask

    task automatic test_idle_zeros();
        bit tail[] = '{1, 0, 1, 0};
        drive(1'b0, 1'b1);
        clock_edge();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0);
            checks++;
            if (out_ov !== 1'b0 || out_nov !== 1'b0) begin
                failures++;
                $display("[TB] FAIL idle_bit%0d: out_ov=%b out_nov=%b expected 0", i + 1, out_ov, out_nov);
            end
            clock_edge();
        end
        foreach (tail[i]) begin
            drive(tail[i], 1'b0);
            checks++;
            if (out_ov !== (i == 3) || out_nov !== (i == 3)) begin
                failures++;
                $display("[TB] FAIL idle_tail%0d: out_ov=%b out_nov=%b expected %b",
                         i + 1, out_ov, out_nov, (i == 3));
            end
            clock_edge();
        end
    endtask

`ifdef MEALY_FSM_1010_CNT_EN
    task automatic test_counter();
        bit pat[] = '{1, 0, 1, 0};
        drive(1'b0, 1'b1);
        clock_edge();
        for (int k = 1; k <= 5; k++) begin
            foreach (pat[i]) begin
                drive(pat[i], 1'b0);
                clock_edge();
            end
            checks++;
            if (cnt_nov !== 2'((k < 3) ? k : 3) || cnt_ov !== 2'(mcnt_ov)) begin
                failures++;
                $display("[TB] FAIL count_pat%0d: cnt_nov=%0d cnt_ov=%0d expected %0d %0d",
                         k, cnt_nov, cnt_ov, (k < 3) ? k : 3, mcnt_ov);
            end
        end
        drive(1'b0, 1'b1);
        clock_edge();
        checks++;
        if (cnt_ov !== 2'd0 || cnt_nov !== 2'd0) begin
            failures++;
            $display("[TB] FAIL count_clear: cnt_ov=%0d cnt_nov=%0d expected 0", cnt_ov, cnt_nov);
        end
    endtask
`endif

    task automatic test_random();
        drive(1'b0, 1'b1);
        clock_edge();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom), ($urandom_range(0, 39) == 0));
            checks++;
            if (out_ov !== exp_ov() || out_nov !== exp_nov()) begin
                failures++;
                $display("[TB] FAIL rand_cyc%0d: out_ov=%b out_nov=%b expected %b %b",
                         i, out_ov, out_nov, exp_ov(), exp_nov());
            end
            clock_edge();
`ifdef MEALY_FSM_1010_CNT_EN
            checks++;
            if (cnt_ov !== 2'(mcnt_ov) || cnt_nov !== 2'(mcnt_nov)) begin
                failures++;
                $display("[TB] FAIL rand_cnt%0d: cnt_ov=%0d cnt_nov=%0d expected %0d %0d",
                         i, cnt_ov, cnt_nov, mcnt_ov, mcnt_nov);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_alternating();
        test_near_miss();
        test_mid_reset();
        test_idle_zeros();
`ifdef MEALY_FSM_1010_CNT_EN
        test_counter();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
